tri_bus_arbiter: RTL and testbench
==================================

// Module: tri_bus_arbiter
// PURPOSE
//  Parametrised, arbitrated tri-state bus driver. N_SRC sources, WIDTH bits each.
//  Grants one source at a time with round-robin fairness and a bounded hold time.
//  Inserts TURN_CYCLES all-Z turnaround cycles between owners, so no two drivers
//  ever overlap. Sits between datapath producers and the shared processor bus.
// PARAMETERS
//  WIDTH        32  data width of each source and of the bus
//  N_SRC        4   number of requesting sources (2..16)
//  MAX_HOLD     8   max DRIVE cycles before a forced release under contention; 0 = unlimited
//  TURN_CYCLES  1   all-Z cycles between owners (0..3); 0 = direct handover
// PORTS
//  clock      in   1              rising-edge clock
//  reset_n    in   1              asynchronous, active-low reset
//  req        in   N_SRC          per-source bus request, level-sensitive
//  data_in    in   N_SRC*WIDTH    source i data at [i*WIDTH +: WIDTH]
//  grant      out  N_SRC          registered one-hot grant (all 0 = none)
//  bus        out  WIDTH          data_in of the owner while granted, else all Z
//  bus_valid  out  1              1 while bus is driven
//  owner      out  clog2(N_SRC)   index of the current or last grantee
//  idle       out  1              1 in IDLE state
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, grant=0, bus=Z, bus_valid=0, owner=0,
//   rr_ptr=0, hold_cnt=0, turn_cnt=0. Outputs take these values immediately, with no clock.
//  Arbitration: the winner is the first set req bit scanning from rr_ptr upward, wrapping modulo N_SRC.
//  IDLE: if any req is set at edge k, the winner's grant is high after edge k (1-cycle latency); -> DRIVE.
//  DRIVE: bus = data_in[owner] combinationally; bus_valid=1; hold_cnt increments, saturating.
//   Release at the next edge when req[owner]=0, OR when MAX_HOLD!=0, hold_cnt==MAX_HOLD-1,
//   and any other req bit is set. With no contention the owner keeps the bus indefinitely.
//   On release: grant=0, rr_ptr=(owner+1)%N_SRC, then -> TURN (TURN_CYCLES>0).
//   If TURN_CYCLES=0, arbitration runs on the same edge: grant moves directly to the
//   new winner, or -> IDLE if nothing is pending.
//  TURN: bus=Z, bus_valid=0, grant=0 for exactly TURN_CYCLES cycles. On the last cycle's edge:
//   arbitrate -> DRIVE (grant is high the following cycle), or -> IDLE if no req is set.
//  A new grant clears hold_cnt to 0 and updates owner. owner holds its value through TURN/IDLE.
//  Source contract: data_in is held stable while its grant is high. A request dropped
//   mid-cycle still sees its data driven until the edge that clears grant.
//  The old owner re-requesting in TURN competes normally; it has lowest priority via rr_ptr.
//  Invariants: grant is at most one-hot; bus=Z whenever grant=0; bus_valid == |grant.
// TESTING
//  1 reset_n=0 mid-sim, no clock -> grant=0, bus=Z, bus_valid=0, idle=1 at once.
//  2 req=4'b0100, data_in[2]=32'hDEADBEEF -> grant=0100 one edge later, bus=DEADBEEF;
//    req=0 -> grant=0 next edge, one Z cycle, idle=1.
//  3 req=4'b1111 from reset, MAX_HOLD=8 -> owners 0,1,2,3,0 in turn, 8 DRIVE cycles each,
//    1 Z cycle between owners.
//  4 req=4'b0010 alone for 20 cycles -> grant stays 0010 for all 20 cycles (no forced release).
//  5 async reset during DRIVE (bus=A5A5A5A5) -> bus=Z and grant=0 before the next clock edge.
//  6 TURN_CYCLES=0 build: owner 0 drops req, req[3]=1 -> grant 0001->1000 on one edge, no Z cycle.
//  All runs: check the one-hot and Z invariants every cycle.

Source files
------------

// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
//
// Purpose:
//   Round-robin arbiter and tri-state driver for a shared bus. It grants one
//   of N_SRC sources at a time and puts the owner's data on the bus. The owner
//   is forced to release the bus after MAX_HOLD cycles when another source is
//   waiting. TURN_CYCLES all-Z cycles are inserted between owners so that two
//   drivers never overlap.
//
// Parameters:
//   WIDTH        data width of each source and of the bus
//   N_SRC        number of requesting sources (2..16)
//   MAX_HOLD     drive cycles before a forced release under contention;
//                0 means the owner may hold the bus without limit
//   TURN_CYCLES  number of all-Z cycles between owners (0..3); 0 = direct handover
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous, active-low reset
//   req        in   per-source request, level-sensitive
//   data_in    in   source i data at [i*WIDTH +: WIDTH]
//   grant      out  registered one-hot grant (all zero = no owner)
//   bus        out  owner's data while granted, otherwise all Z
//   bus_valid  out  1 while the bus is driven
//   owner      out  index of the current or most recent grantee
//   idle       out  1 while the arbiter is in IDLE
//   dbg_state  out  encoded FSM state (0 IDLE, 1 DRIVE, 2 TURN)
//
// Handshake: req/grant is level-based. A source raises req and keeps its data
// stable while its grant bit is high. A source releases the bus by dropping
// req; grant falls on the next rising edge. Until that edge the bus still
// carries that source's data.
// -----------------------------------------------------------------------------
module tri_bus_arbiter #(
    parameter int WIDTH       = 32,
    parameter int N_SRC       = 4,
    parameter int MAX_HOLD    = 8,
    parameter int TURN_CYCLES = 1,
    localparam int OWN_W      = $clog2(N_SRC)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*WIDTH-1:0] data_in,
    output logic [N_SRC-1:0]       grant,
    output logic [WIDTH-1:0]       bus,
    output logic                   bus_valid,
    output logic [OWN_W-1:0]       owner,
    output logic                   idle,
    output logic [1:0]             dbg_state
);

    localparam int HOLD_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);

    // The hold counter saturates at MAX_HOLD-1. This keeps the forced-release
    // compare true when contention shows up after a long uncontended hold.
    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    localparam logic [1:0] TURN_LAST =
        (TURN_CYCLES == 0) ? 2'd0 : 2'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t             r_state,    w_state_nx;
    logic [N_SRC-1:0]   r_grant,    w_grant_nx;
    logic [OWN_W-1:0]   r_owner,    w_owner_nx;
    logic [OWN_W-1:0]   r_rr_ptr,   w_rr_ptr_nx;
    logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nx;
    logic [1:0]         r_turn_cnt, w_turn_cnt_nx;

    logic [OWN_W-1:0]   w_owner_inc;
    logic [OWN_W-1:0]   w_arb_ptr;
    logic [OWN_W-1:0]   w_win_idx;
    logic [N_SRC-1:0]   w_win_onehot;
    logic               w_win_found;
    logic               w_others;
    logic               w_release;
    logic [WIDTH-1:0]   w_owner_data;

    assign w_owner_inc = (r_owner == OWN_W'(N_SRC - 1)) ? '0 : r_owner + OWN_W'(1);

    // In DRIVE, arbitration only matters for a zero-turnaround handover. The
    // pointer then has to be the post-release value (owner+1), which has not
    // been registered yet. In IDLE and TURN the registered pointer is current.
    assign w_arb_ptr = (r_state == ST_DRIVE) ? w_owner_inc : r_rr_ptr;

    // Round-robin scan: the lowest offset from w_arb_ptr wins. The loop walks
    // offsets downward, so the last hit is the closest one.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            v_idx = (int'(w_arb_ptr) + k) % N_SRC;
            if (req[OWN_W'(v_idx)]) begin
                w_win_found = 1'b1;
                w_win_idx   = OWN_W'(v_idx);
            end
        end
    end

    assign w_win_onehot = N_SRC'(1) << w_win_idx;

    // r_grant is one-hot on the owner in DRIVE, so masking with it leaves only
    // the other requesters.
    assign w_others  = |(req & ~r_grant);
    assign w_release = !req[r_owner] ||
                       ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_SAT) && w_others);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_grant    <= w_grant_nx;
            r_owner    <= w_owner_nx;
            r_rr_ptr   <= w_rr_ptr_nx;
            r_hold_cnt <= w_hold_cnt_nx;
            r_turn_cnt <= w_turn_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_grant_nx    = r_grant;
        w_owner_nx    = r_owner;
        w_rr_ptr_nx   = r_rr_ptr;
        w_hold_cnt_nx = r_hold_cnt;
        w_turn_cnt_nx = r_turn_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nx    = ST_DRIVE;
                    w_grant_nx    = w_win_onehot;
                    w_owner_nx    = w_win_idx;
                    w_hold_cnt_nx = '0;
                end
            end

            ST_DRIVE: begin
                if (w_release) begin
                    w_grant_nx  = '0;
                    w_rr_ptr_nx = w_owner_inc;
                    if (TURN_CYCLES != 0) begin
                        w_state_nx    = ST_TURN;
                        w_turn_cnt_nx = '0;
                    end else if (w_win_found) begin
                        w_grant_nx    = w_win_onehot;
                        w_owner_nx    = w_win_idx;
                        w_hold_cnt_nx = '0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else if (r_hold_cnt != HOLD_SAT) begin
                    w_hold_cnt_nx = r_hold_cnt + HOLD_W'(1);
                end
            end

            ST_TURN: begin
                if (r_turn_cnt == TURN_LAST) begin
                    if (w_win_found) begin
                        w_state_nx    = ST_DRIVE;
                        w_grant_nx    = w_win_onehot;
                        w_owner_nx    = w_win_idx;
                        w_hold_cnt_nx = '0;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    w_turn_cnt_nx = r_turn_cnt + 2'd1;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
                w_grant_nx = '0;
            end
        endcase
    end

    assign w_owner_data = data_in[r_owner*WIDTH +: WIDTH];

    // The bus enable comes straight from the registered grant. Reset therefore
    // releases the bus immediately, and the bus is never driven with grant at 0.
    assign grant     = r_grant;
    assign bus_valid = |r_grant;
    assign bus       = bus_valid ? w_owner_data : {WIDTH{1'bz}};
    assign owner     = r_owner;
    assign idle      = (r_state == ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
module tb_tri_bus_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MH = 8;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  // u_dut0 uses TURN_CYCLES=1 and u_dut1 uses TURN_CYCLES=0. Each has its own stimulus.
  logic [N-1:0]   req0  = '0;
  logic [N-1:0]   req1  = '0;
  logic [N*W-1:0] data0 = '0;
  logic [N*W-1:0] data1 = '0;
  wire  [N-1:0]   grant0, grant1;
  wire  [W-1:0]   bus0, bus1;
  wire            bv0, bv1, idle0, idle1;
  wire  [1:0]     own0, own1, st0, st1;

  tri_bus_arbiter #(.WIDTH(W), .N_SRC(N), .MAX_HOLD(MH), .TURN_CYCLES(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .req(req0), .data_in(data0),
    .grant(grant0), .bus(bus0), .bus_valid(bv0), .owner(own0), .idle(idle0),
    .dbg_state(st0)
  );

  tri_bus_arbiter #(.WIDTH(W), .N_SRC(N), .MAX_HOLD(MH), .TURN_CYCLES(0)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .req(req1), .data_in(data1),
    .grant(grant1), .bus(bus1), .bus_valid(bv1), .owner(own1), .idle(idle1),
    .dbg_state(st1)
  );

  int total = 0;
  int bad   = 0;
  bit rnd_data = 1'b1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Bus ownership is described by plain integers:
  //   mo_owner: owner index, or -1 when nobody drives
  //   mo_held:  drive cycles completed so far
  //   mo_gap:   remaining Z cycles
  //   mo_ptr:   round-robin start index
  //   mo_last:  most recent grantee
  int mo_owner[2], mo_held[2], mo_gap[2], mo_ptr[2], mo_last[2];

  function automatic int turn_of(int m);
    return (m == 0) ? 1 : 0;
  endfunction

  function automatic void model_reset(int m);
    mo_owner[m] = -1; mo_held[m] = 0; mo_gap[m] = 0; mo_ptr[m] = 0; mo_last[m] = 0;
  endfunction

  function automatic void model_arb(int m, logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (mo_ptr[m] + k) % N;
      if (r[i]) begin
        mo_owner[m] = i; mo_held[m] = 0; mo_last[m] = i;
        return;
      end
    end
  endfunction

  // Advance the model across one rising edge with request vector r.
  function automatic void model_step(int m, logic [N-1:0] r);
    if (mo_owner[m] >= 0) begin
      int o;
      logic [N-1:0] others;
      o = mo_owner[m];
      others = r & ~(N'(1) << o);
      if (!r[o] || (MH != 0 && mo_held[m] >= MH - 1 && others != 0)) begin
        mo_ptr[m]   = (o + 1) % N;
        mo_owner[m] = -1;
        if (turn_of(m) > 0) mo_gap[m] = turn_of(m);
        else model_arb(m, r);
      end else begin
        mo_held[m]++;
      end
    end else if (mo_gap[m] > 0) begin
      mo_gap[m]--;
      if (mo_gap[m] == 0) model_arb(m, r);
    end else begin
      model_arb(m, r);
    end
  endfunction

  task automatic compare(input int m);
    logic [N-1:0]   g, want_g;
    logic [N*W-1:0] d;
    logic           bv, id;
    logic [1:0]     ow;
    logic [W-1:0]   b;
    g  = (m == 0) ? grant0 : grant1;
    bv = (m == 0) ? bv0    : bv1;
    id = (m == 0) ? idle0  : idle1;
    ow = (m == 0) ? own0   : own1;
    b  = (m == 0) ? bus0   : bus1;
    d  = (m == 0) ? data0  : data1;
    want_g = (mo_owner[m] >= 0) ? (N'(1) << mo_owner[m]) : '0;
    check($sformatf("grant%0d", m), 64'(g), 64'(want_g));
    check($sformatf("bus_valid%0d", m), 64'(bv), 64'(mo_owner[m] >= 0));
    check($sformatf("idle%0d", m), 64'(id), 64'(mo_owner[m] < 0 && mo_gap[m] == 0));
    check($sformatf("owner%0d", m), 64'(ow), 64'(mo_last[m]));
    if (mo_owner[m] >= 0)
      check($sformatf("bus%0d", m), 64'(b), 64'(d[mo_owner[m]*W +: W]));
    check($sformatf("onehot%0d", m), 64'($onehot0(g)), 64'(1));
    check($sformatf("valid_eq_grant%0d", m), 64'(bv), 64'(|g));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: apply inputs, step both models across the next
  // rising edge, then compare at the following falling edge.
  task automatic tick(input logic [N-1:0] r0, input logic [N-1:0] r1);
    req0 = r0;
    req1 = r1;
    if (rnd_data) begin
      for (int i = 0; i < N; i++) begin
        if (mo_owner[0] != i) data0[i*W +: W] = $urandom;
        if (mo_owner[1] != i) data1[i*W +: W] = $urandom;
      end
    end
    model_step(0, r0);
    model_step(1, r1);
    @(negedge clock);
    compare(0);
    compare(1);
  endtask

  // Assert reset between clock edges, check outputs without a clock, then
  // release the reset on a falling edge.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_grant0", 64'(grant0), 64'(0));
    check("rst_bv0",    64'(bv0),    64'(0));
    check("rst_idle0",  64'(idle0),  64'(1));
    check("rst_owner0", 64'(own0),   64'(0));
    check("rst_grant1", 64'(grant1), 64'(0));
    check("rst_bv1",    64'(bv1),    64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    model_reset(0);
    model_reset(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset(0);
    model_reset(1);
    async_reset();

    // Single requester, then release with one Z cycle.
    rnd_data = 1'b0;
    data0[2*W +: W] = 32'hDEADBEEF;
    tick(4'b0100, 4'b0000);
    check("t2_grant", 64'(grant0), 64'(4'b0100));
    check("t2_bus",   64'(bus0),   64'(32'hDEADBEEF));
    tick(4'b0000, 4'b0000);
    check("t2_drop_grant", 64'(grant0), 64'(0));
    check("t2_turn_idle",  64'(idle0),  64'(0));
    tick(4'b0000, 4'b0000);
    check("t2_idle", 64'(idle0), 64'(1));

    // Full contention: 8-cycle slices in rotation, 1 Z cycle between them on
    // u_dut0 and none on u_dut1.
    async_reset();
    rnd_data = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      int c;
      tick(4'b1111, 4'b1111);
      c = k - 1;
      check("t3_rotate",  64'(grant0), 64'((c % 9 < 8) ? (N'(1) << ((c / 9) % 4)) : N'(0)));
      check("t3_rotate0", 64'(grant1), 64'(N'(1) << ((c / 8) % 4)));
    end

    // A lone requester is never forced off the bus.
    repeat (3) tick(4'b0000, 4'b0000);
    tick(4'b0010, 4'b0000);
    for (int k = 0; k < 20; k++) begin
      tick(4'b0010, 4'b0000);
      check("t4_hold", 64'(grant0), 64'(4'b0010));
    end

    // Async reset while driving.
    repeat (3) tick(4'b0000, 4'b0000);
    rnd_data = 1'b0;
    data0[1*W +: W] = 32'hA5A5A5A5;
    tick(4'b0010, 4'b0000);
    check("t5_bus", 64'(bus0), 64'(32'hA5A5A5A5));
    async_reset();
    rnd_data = 1'b1;

    // Direct handover with no Z cycle on the zero-turnaround instance.
    tick(4'b0000, 4'b0001);
    check("t6_first", 64'(grant1), 64'(4'b0001));
    tick(4'b0000, 4'b0001);
    tick(4'b0000, 4'b1000);
    check("t6_handover", 64'(grant1), 64'(4'b1000));
    check("t6_no_gap",   64'(bv1),    64'(1));

    // Random traffic. Requests change rarely, so forced releases also occur.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] r0, r1;
      r0 = ($urandom_range(0, 11) == 0) ? N'($urandom_range(0, 15)) : req0;
      r1 = ($urandom_range(0, 11) == 0) ? N'($urandom_range(0, 15)) : req1;
      if ($urandom_range(0, 599) == 0) async_reset();
      else tick(r0, r1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Simulation time limit.
  initial begin
    #2000000;
    $display("FAIL timeout: got no_finish want finish");
    $fatal(1, "timeout");
  end
endmodule
